instruction_decoder_pipe: RTL and testbench

Parametrised, pipelined successor to the picoprocessor instruction decoder. Sits between program memory and the datapath. Registers each fetched instruction under a valid/ready handshake and decodes it into register enables, source select and branch strobes. Adds stall, taken-jump squash, and saturating retired/NOP counters for performance monitoring.

---
 rtl/picoproc_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 33 +++
 rtl/instruction_decoder_pipe.sv | 140 ++++++++++++++
 tb/tb_instruction_decoder_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/picoproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picoproc_pkg
//  Description : Shared instruction-class encodings, select codes and default
//                register indices for the picoprocessor decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package picoproc_pkg;

    localparam int unsigned c_default_i_idx  = 6;
    localparam int unsigned c_default_dm_idx = 7;

    typedef enum logic [2:0] {
        CLS_LDI = 3'd0,
        CLS_MOV = 3'd1,
        CLS_ALU = 3'd2,
        CLS_JMP = 3'd3,
        CLS_JNZ = 3'd4
    } instr_class_t;

    // Source-mux codes that sit just above the NDST register selects.
    function automatic int unsigned imm_sel(input int unsigned dst_w);
        return 2 ** dst_w;
    endfunction

    function automatic int unsigned self_sel(input int unsigned dst_w);
        return (2 ** dst_w) + 1;
    endfunction

    function automatic int unsigned rst_sel(input int unsigned dst_w);
        return (2 ** dst_w) + 2;
    endfunction

    // Class is a prefix code on the top four instruction bits.
    function automatic instr_class_t classify(input logic [3:0] top);
        if (!top[3])      return CLS_LDI;
        else if (!top[2]) return CLS_MOV;
        else if (!top[1]) return CLS_ALU;
        else if (!top[0]) return CLS_JMP;
        else              return CLS_JNZ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    // Clear has priority over an increment on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instruction_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder_pipe
//  Description : Registered picoprocessor instruction decoder with stall,
//                taken-jump squash and retired/NOP performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder_pipe
    import picoproc_pkg::*;
#(
    parameter  int unsigned DST_W  = 3,
    parameter  int unsigned I_IDX  = c_default_i_idx,
    parameter  int unsigned DM_IDX = c_default_dm_idx,
    parameter  int unsigned CW     = 16,
    localparam int unsigned IW     = 2 * DST_W + 2,
    localparam int unsigned NDST   = 2 ** DST_W
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic [IW-1:0]   instr_in,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            stall,
    input  logic            jump_taken,
    input  logic            cnt_clr,
    output logic [NDST:0]   reg_en,
    output logic [DST_W:0]  source_sel,
    output logic [DST_W:0]  imm,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic            jmp,
    output logic            jmp_nz,
    output logic [CW-1:0]   retired_cnt,
    output logic [CW-1:0]   nop_cnt
);

    localparam logic [DST_W:0]   c_IMM_SEL  = (DST_W + 1)'(imm_sel(DST_W));
    localparam logic [DST_W:0]   c_SELF_SEL = (DST_W + 1)'(self_sel(DST_W));
    localparam logic [DST_W:0]   c_RST_SEL  = (DST_W + 1)'(rst_sel(DST_W));
    localparam logic [DST_W-1:0] c_I_IDX    = DST_W'(I_IDX);
    localparam logic [DST_W-1:0] c_DM_IDX   = DST_W'(DM_IDX);

    logic [IW-1:0]    r_ir;
    logic             r_ir_valid;
    logic             r_squash;

    instr_class_t     w_cls;
    logic [DST_W-1:0] w_dst;
    logic [DST_W-1:0] w_src;
    logic             w_has_dst;
    logic             w_live;
    logic             w_nop;

    assign instr_ready = !stall;

    // The slot loaded on the edge that ends a taken-jump cycle is killed.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_squash   <= 1'b0;
        end else if (!stall) begin
            r_ir       <= instr_in;
            r_ir_valid <= instr_valid && !(jump_taken && !stall);
            r_squash   <= jump_taken;
        end
    end

    assign w_cls     = classify(r_ir[IW-1 -: 4]);
    assign w_src     = r_ir[DST_W-1:0];
    assign w_dst     = (w_cls == CLS_LDI) ? r_ir[IW-2 -: DST_W]
                                          : r_ir[2*DST_W-1:DST_W];
    assign w_has_dst = (w_cls == CLS_LDI) || (w_cls == CLS_MOV);
    assign w_live    = r_ir_valid && !r_squash && !stall;
    assign w_nop     = w_live && (w_cls == CLS_MOV) && (w_dst == w_src);
    assign imm       = r_ir[DST_W:0];

    always_comb begin
        reg_en     = '0;
        source_sel = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        if (sync_reset) begin
            reg_en     = '1;
            source_sel = c_RST_SEL;
        end else if (w_live) begin
            source_sel = {1'b0, w_src};
            i_sel      = !(w_has_dst && (w_dst == c_I_IDX));
            case (w_cls)
                CLS_LDI: begin
                    reg_en[{1'b0, w_dst}] = 1'b1;
                    source_sel            = c_IMM_SEL;
                end
                CLS_MOV: begin
                    reg_en[{1'b0, w_dst}] = 1'b1;
                    if (w_dst == w_src) begin
                        source_sel = c_SELF_SEL;
                    end
                    // Reading data memory post-increments the pointer.
                    if (w_src == c_DM_IDX) begin
                        reg_en[I_IDX] = 1'b1;
                    end
                end
                CLS_ALU: begin
                    reg_en[NDST] = 1'b1;
                    x_sel        = r_ir[IW-4];
                    y_sel        = r_ir[IW-5];
                end
                CLS_JMP: jmp    = 1'b1;
                CLS_JNZ: jmp_nz = 1'b1;
                default: ;
            endcase
            if (w_has_dst && (w_dst == c_DM_IDX)) begin
                reg_en[I_IDX] = 1'b1;
            end
        end
    end

    sat_counter #(.CW(CW)) u_retired_cnt (
        .clk   (clk),
        .rst   (sync_reset),
        .inc   (w_live),
        .clr   (cnt_clr),
        .count (retired_cnt)
    );

    sat_counter #(.CW(CW)) u_nop_cnt (
        .clk   (clk),
        .rst   (sync_reset),
        .inc   (w_nop),
        .clr   (cnt_clr),
        .count (nop_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decoder_pipe
//  Description : Directed self-checking bench for instruction_decoder_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder_pipe;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic [7:0]  instr_in;
    logic        instr_valid, stall, jump_taken, cnt_clr;
    logic        instr_ready, i_sel, x_sel, y_sel, jmp, jmp_nz;
    logic [8:0]  reg_en;
    logic [3:0]  source_sel, imm;
    logic [15:0] retired_cnt, nop_cnt;

    logic        s_ready, s_i_sel, s_x_sel, s_y_sel, s_jmp, s_jmp_nz;
    logic [8:0]  s_reg_en;
    logic [3:0]  s_source_sel, s_imm, s_retired, s_nop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_decoder_pipe u_dut (
        .clk(clk), .sync_reset(sync_reset), .instr_in(instr_in),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .stall(stall),
        .jump_taken(jump_taken), .cnt_clr(cnt_clr), .reg_en(reg_en),
        .source_sel(source_sel), .imm(imm), .i_sel(i_sel), .x_sel(x_sel),
        .y_sel(y_sel), .jmp(jmp), .jmp_nz(jmp_nz),
        .retired_cnt(retired_cnt), .nop_cnt(nop_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    instruction_decoder_pipe #(.CW(4)) u_dut_sat (
        .clk(clk), .sync_reset(sync_reset), .instr_in(instr_in),
        .instr_valid(instr_valid), .instr_ready(s_ready), .stall(stall),
        .jump_taken(jump_taken), .cnt_clr(cnt_clr), .reg_en(s_reg_en),
        .source_sel(s_source_sel), .imm(s_imm), .i_sel(s_i_sel), .x_sel(s_x_sel),
        .y_sel(s_y_sel), .jmp(s_jmp), .jmp_nz(s_jmp_nz),
        .retired_cnt(s_retired), .nop_cnt(s_nop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] v);
        instr_in    = v;
        instr_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        accept(8'h3A);
        #1 sync_reset = 1'b1;
        #1;
        total++; if (reg_en !== 9'h1FF) begin bad++; $display("FAIL reset_reg_en got=%h want=1ff", reg_en); end
        total++; if (source_sel !== 4'd10) begin bad++; $display("FAIL reset_source_sel got=%0d want=10", source_sel); end
        total++; if (jmp !== 1'b0 || i_sel !== 1'b0) begin bad++; $display("FAIL reset_strobes jmp=%b i_sel=%b want=0", jmp, i_sel); end
        instr_valid = 1'b0;
        #1 sync_reset = 1'b0;
        tick();
        total++; if (retired_cnt !== 16'd0 || nop_cnt !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", retired_cnt, nop_cnt); end
        total++; if (reg_en !== 9'h000) begin bad++; $display("FAIL reset_bubble_reg_en got=%h want=000", reg_en); end
    endtask

    task automatic test_decode();
        accept(8'h3A);
        total++; if (reg_en !== 9'h008 || source_sel !== 4'd8) begin bad++; $display("FAIL ldi_3a got=%h/%0d want=008/8", reg_en, source_sel); end
        total++; if (imm !== 4'hA || i_sel !== 1'b1) begin bad++; $display("FAIL ldi_3a_imm got=%h/%b want=a/1", imm, i_sel); end
        accept(8'hBE);
        total++; if (reg_en !== 9'h0C0 || source_sel !== 4'd6) begin bad++; $display("FAIL mov_be got=%h/%0d want=0c0/6", reg_en, source_sel); end
        accept(8'hD5);
        total++; if (reg_en !== 9'h100 || x_sel !== 1'b1 || y_sel !== 1'b0) begin bad++; $display("FAIL alu_d5 got=%h/x%b/y%b want=100/x1/y0", reg_en, x_sel, y_sel); end
        total++; if (source_sel !== 4'd5) begin bad++; $display("FAIL alu_d5_src got=%0d want=5", source_sel); end
        accept(8'h60);
        total++; if (reg_en !== 9'h040 || i_sel !== 1'b0) begin bad++; $display("FAIL ldi_i got=%h/%b want=040/0", reg_en, i_sel); end
        accept(8'h9F);
        total++; if (reg_en !== 9'h048 || source_sel !== 4'd7) begin bad++; $display("FAIL mov_from_dm got=%h/%0d want=048/7", reg_en, source_sel); end
    endtask

    task automatic test_nop();
        // ir holds a live move here, so this edge also tests clear-beats-increment.
        cnt_clr     = 1'b1;
        instr_valid = 1'b0;
        tick();
        cnt_clr = 1'b0;
        total++; if (retired_cnt !== 16'd0) begin bad++; $display("FAIL clr_wins got=%0d want=0", retired_cnt); end
        accept(8'h92);
        total++; if (source_sel !== 4'd9 || reg_en !== 9'h004) begin bad++; $display("FAIL nop_92 got=%0d/%h want=9/004", source_sel, reg_en); end
        total++; if (nop_cnt !== 16'd0 || retired_cnt !== 16'd0) begin bad++; $display("FAIL nop_cnt_before got=%0d/%0d want=0/0", nop_cnt, retired_cnt); end
        instr_valid = 1'b0;
        tick();
        total++; if (nop_cnt !== 16'd1 || retired_cnt !== 16'd1) begin bad++; $display("FAIL nop_cnt_after got=%0d/%0d want=1/1", nop_cnt, retired_cnt); end
    endtask

    task automatic test_jump();
        accept(8'hE5);
        total++; if (jmp !== 1'b1 || jmp_nz !== 1'b0 || source_sel !== 4'd5) begin bad++; $display("FAIL jmp_e5 got=%b/%b/%0d want=1/0/5", jmp, jmp_nz, source_sel); end
        jump_taken = 1'b1;
        accept(8'h11);
        jump_taken = 1'b0;
        total++; if (reg_en !== 9'h000 || jmp !== 1'b0 || imm !== 4'h1) begin bad++; $display("FAIL squash_slot got=%h/%b/%h want=000/0/1", reg_en, jmp, imm); end
        total++; if (retired_cnt !== 16'd2) begin bad++; $display("FAIL squash_jmp_counted got=%0d want=2", retired_cnt); end
        accept(8'h11);
        total++; if (retired_cnt !== 16'd2 || reg_en !== 9'h002) begin bad++; $display("FAIL squash_not_counted got=%0d/%h want=2/002", retired_cnt, reg_en); end
        accept(8'hF3);
        total++; if (jmp_nz !== 1'b1 || jmp !== 1'b0 || source_sel !== 4'd3 || retired_cnt !== 16'd3) begin bad++; $display("FAIL jnz_f3 got=%b/%b/%0d/%0d want=1/0/3/3", jmp_nz, jmp, source_sel, retired_cnt); end
    endtask

    task automatic test_stall();
        accept(8'h3A);
        stall      = 1'b1;
        jump_taken = 1'b1;
        instr_in   = 8'hD5;
        #1;
        total++; if (instr_ready !== 1'b0 || reg_en !== 9'h000) begin bad++; $display("FAIL stall_gate got=%b/%h want=0/000", instr_ready, reg_en); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (reg_en !== 9'h000 || imm !== 4'hA || source_sel !== 4'd0) begin bad++; $display("FAIL stall_hold_%0d got=%h/%h/%0d want=000/a/0", k, reg_en, imm, source_sel); end
        end
        stall      = 1'b0;
        jump_taken = 1'b0;
        #1;
        total++; if (reg_en !== 9'h008 || instr_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%b want=008/1", reg_en, instr_ready); end
        tick();
        total++; if (reg_en !== 9'h100) begin bad++; $display("FAIL stall_jump_ignored got=%h want=100", reg_en); end
    endtask

    task automatic test_bubble();
        instr_valid = 1'b0;
        tick();
        total++; if (reg_en !== 9'h000 || source_sel !== 4'd0 || i_sel !== 1'b0) begin bad++; $display("FAIL bubble got=%h/%0d/%b want=000/0/0", reg_en, source_sel, i_sel); end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        accept(8'h3A);
        cnt_clr = 1'b0;
        repeat (20) tick();
        total++; if (retired_cnt !== 16'd20) begin bad++; $display("FAIL retired_run got=%0d want=20", retired_cnt); end
        total++; if (s_retired !== 4'hF) begin bad++; $display("FAIL retired_saturate got=%h want=f", s_retired); end
        tick();
        total++; if (s_retired !== 4'hF) begin bad++; $display("FAIL retired_stays got=%h want=f", s_retired); end
    endtask

    initial begin
        sync_reset  = 1'b1;
        instr_in    = 8'h00;
        instr_valid = 1'b0;
        stall       = 1'b0;
        jump_taken  = 1'b0;
        cnt_clr     = 1'b0;
        #12 sync_reset = 1'b0;
        test_reset();
        test_decode();
        test_nop();
        test_jump();
        test_stall();
        test_bubble();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
